// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver and its 32-bit word assembler.
package uart_rx_pkg;

  localparam int unsigned WordWidth    = 32;
  localparam int unsigned BytesPerWord = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level 8N1 receiver: input synchroniser, bit timer and frame FSM.
// Emits single-cycle strobes on the stop-bit sample; the parent registers them.
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 500000,
  parameter int unsigned BIT_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       uart_rxd,
  output logic       byte_done_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HalfBit      = CyclesPerBit / 2;
  localparam int unsigned CntW         = $clog2(CyclesPerBit);

  logic [1:0]      sync_q;
  logic            rxs;
  logic            en_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            bit_end, half_end;

  assign rxs      = sync_q[1];
  assign bit_end  = (cnt_q == CntW'(CyclesPerBit - 1));
  assign half_end = (cnt_q == CntW'(HalfBit - 1));
  assign byte_o   = shift_q;
  assign busy_o   = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_o = 1'b0;
    frame_err_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (half_end) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done_o = 1'b1;
            state_d     = StIdle;
          end else begin
            frame_err_o = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!en) begin
      state_d     = StIdle;
      cnt_d       = '0;
      byte_done_o = 1'b0;
      frame_err_o = 1'b0;
    end else if (!en_q && !rxs) begin
      // A low line at enable time is not a start edge; wait for it to go idle.
      state_d = StWaitHigh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      en_q      <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], uart_rxd};
      en_q      <= en;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/uart_rx_word32.sv
// UART receiver assembling LSB-first bytes into 32-bit words, with framing-error reporting.
// Define UART_RX_TIMEOUT_EN to drop partial words after TIMEOUT_BITS idle bit periods.
module uart_rx_word32
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 500000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        uart_rxd,
  output logic        rx_byte_valid,
  output logic [7:0]  rx_byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [1:0]  byte_index,
  output logic        frame_err,
  output logic        rx_busy,
  output logic        timeout
);

  logic       byte_done;
  logic [7:0] byte_s;
  logic       frame_err_s;

  uart_rx_byte #(
    .CLK_HZ  (CLK_HZ),
    .BIT_RATE(BIT_RATE)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .uart_rxd   (uart_rxd),
    .byte_done_o(byte_done),
    .byte_o     (byte_s),
    .frame_err_o(frame_err_s),
    .busy_o     (rx_busy)
  );

  logic                 rx_byte_valid_q, rx_byte_valid_d;
  logic [7:0]           rx_byte_data_q, rx_byte_data_d;
  logic                 word_valid_q, word_valid_d;
  logic [WordWidth-1:0] word_data_q, word_data_d;
  logic [23:0]          word_buf_q, word_buf_d;
  logic [1:0]           byte_index_q, byte_index_d;
  logic                 frame_err_q, frame_err_d;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned TmoW          = $clog2(TimeoutCycles);

  logic            timeout_q, timeout_d;
  logic            tmo_run_q, tmo_run_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout = timeout_q;
`else
  logic unused_timeout_bits;
  assign unused_timeout_bits = ^TIMEOUT_BITS;
  assign timeout             = 1'b0;
`endif

  always_comb begin
    rx_byte_valid_d = 1'b0;
    rx_byte_data_d  = rx_byte_data_q;
    word_valid_d    = 1'b0;
    word_data_d     = word_data_q;
    word_buf_d      = word_buf_q;
    byte_index_d    = byte_index_q;
    frame_err_d     = 1'b0;

    if (byte_done) begin
      rx_byte_valid_d = 1'b1;
      rx_byte_data_d  = byte_s;
      if (byte_index_q == 2'(BytesPerWord - 1)) begin
        word_valid_d = 1'b1;
        word_data_d  = {byte_s, word_buf_q};
        byte_index_d = '0;
      end else begin
        case (byte_index_q)
          2'd0:    word_buf_d[7:0]   = byte_s;
          2'd1:    word_buf_d[15:8]  = byte_s;
          default: word_buf_d[23:16] = byte_s;
        endcase
        byte_index_d = byte_index_q + 1'b1;
      end
    end

    if (frame_err_s) begin
      frame_err_d  = 1'b1;
      byte_index_d = '0;
    end

`ifdef UART_RX_TIMEOUT_EN
    timeout_d = 1'b0;
    tmo_run_d = tmo_run_q;
    tmo_cnt_d = tmo_cnt_q;
    if (byte_done) begin
      // Only a partial word needs a watchdog; a completed word stops it.
      tmo_run_d = (byte_index_d != 2'd0);
      tmo_cnt_d = '0;
    end else if (tmo_run_q) begin
      if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
        timeout_d    = 1'b1;
        byte_index_d = '0;
        tmo_run_d    = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
    if (!en) begin
      timeout_d = 1'b0;
      tmo_run_d = 1'b0;
    end
`endif

    if (!en) byte_index_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_valid_q <= 1'b0;
      rx_byte_data_q  <= '0;
      word_valid_q    <= 1'b0;
      word_data_q     <= '0;
      word_buf_q      <= '0;
      byte_index_q    <= '0;
      frame_err_q     <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      timeout_q       <= 1'b0;
      tmo_run_q       <= 1'b0;
      tmo_cnt_q       <= '0;
`endif
    end else begin
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_byte_data_q  <= rx_byte_data_d;
      word_valid_q    <= word_valid_d;
      word_data_q     <= word_data_d;
      word_buf_q      <= word_buf_d;
      byte_index_q    <= byte_index_d;
      frame_err_q     <= frame_err_d;
`ifdef UART_RX_TIMEOUT_EN
      timeout_q       <= timeout_d;
      tmo_run_q       <= tmo_run_d;
      tmo_cnt_q       <= tmo_cnt_d;
`endif
    end
  end

  assign rx_byte_valid = rx_byte_valid_q;
  assign rx_byte_data  = rx_byte_data_q;
  assign word_valid    = word_valid_q;
  assign word_data     = word_data_q;
  assign byte_index    = byte_index_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_rx_word32.sv
// Directed bench for uart_rx_word32 at 52 clocks per bit; pulse counters sampled on negedge.
module tb_uart_rx_word32;

  localparam int Bit  = 52;
  localparam int Half = 26;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        uart_rxd;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte_data;
  logic        word_valid;
  logic [31:0] word_data;
  logic [1:0]  byte_index;
  logic        frame_err;
  logic        rx_busy;
  logic        timeout;

  uart_rx_word32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .uart_rxd     (uart_rxd),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte_data (rx_byte_data),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .byte_index   (byte_index),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_byte = 0, n_word = 0, n_ferr = 0, n_tmo = 0;
  int         valid_cyc = 0;
  logic [7:0] last_byte = '0;
  always @(negedge clk) begin
    if (rx_byte_valid) begin
      n_byte    <= n_byte + 1;
      last_byte <= rx_byte_data;
      valid_cyc <= cyc;
    end
    if (word_valid) n_word <= n_word + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (timeout)    n_tmo  <= n_tmo + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int fall_cyc = 0;
  int b_byte, b_word, b_ferr, b_tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic snap();
    b_byte = n_byte;
    b_word = n_word;
    b_ferr = n_ferr;
    b_tmo  = n_tmo;
  endtask

  // Called at a negedge; returns at a negedge so frames can be sent back to back.
  task automatic send_byte(input logic [7:0] b, input int stop_low_bits);
    uart_rxd = 1'b0;
    fall_cyc = cyc;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (Bit) @(negedge clk);
    end
    if (stop_low_bits > 0) begin
      uart_rxd = 1'b0;
      repeat (Bit * stop_low_bits) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (Bit) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_byte_valid", 32'(rx_byte_valid), 32'd0);
    check("rst_byte_data", 32'(rx_byte_data), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_data", word_data, 32'd0);
    check("rst_byte_index", 32'(byte_index), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte
    snap();
    send_byte(8'hA5, 0);
    repeat (3) @(negedge clk);
    check("single_nbyte", 32'(n_byte - b_byte), 32'd1);
    check("single_data", 32'(last_byte), 32'hA5);
    check("single_index", 32'(byte_index), 32'd1);
    check("single_nword", 32'(n_word - b_word), 32'd0);
    check("single_nferr", 32'(n_ferr - b_ferr), 32'd0);
    check("single_latency_ok", 32'((valid_cyc - fall_cyc) >= 496 && (valid_cyc - fall_cyc) <= 498),
          32'd1);

    // Disable clears the partial word but keeps the last byte
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("en_off_index", 32'(byte_index), 32'd0);
    check("en_off_data_kept", 32'(rx_byte_data), 32'hA5);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Four back-to-back bytes
    snap();
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    repeat (3) @(negedge clk);
    check("word_nword", 32'(n_word - b_word), 32'd1);
    check("word_data", word_data, 32'h12345678);
    check("word_index", 32'(byte_index), 32'd0);
    check("word_nbyte", 32'(n_byte - b_byte), 32'd4);

    // Start-bit glitch
    snap();
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_mid", 32'(rx_busy), 32'd1);
    repeat (5) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (Half - 6) @(negedge clk);
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    check("glitch_nbyte", 32'(n_byte - b_byte), 32'd0);
    check("glitch_nferr", 32'(n_ferr - b_ferr), 32'd0);
    repeat (Bit) @(negedge clk);

    // Framing error in the middle of a word
    snap();
    send_byte(8'h11, 0);
    send_byte(8'h22, 3);
    check("ferr_count", 32'(n_ferr - b_ferr), 32'd1);
    check("ferr_index", 32'(byte_index), 32'd0);
    check("ferr_busy_idle", 32'(rx_busy), 32'd0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    repeat (3) @(negedge clk);
    check("ferr_nword", 32'(n_word - b_word), 32'd1);
    check("ferr_word_data", word_data, 32'h66554433);
    check("ferr_count_after", 32'(n_ferr - b_ferr), 32'd1);

    // Inter-byte idle gap
    snap();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (1100) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
    check("tmo_count", 32'(n_tmo - b_tmo), 32'd1);
    check("tmo_index", 32'(byte_index), 32'd0);
    check("tmo_word_kept", word_data, 32'h66554433);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    repeat (3) @(negedge clk);
    check("tmo_word_data", word_data, 32'h04030201);
`else
    check("notmo_count", 32'(n_tmo - b_tmo), 32'd0);
    check("notmo_index", 32'(byte_index), 32'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    repeat (3) @(negedge clk);
    check("notmo_word_data", word_data, 32'h0201BBAA);
`endif
    check("gap_index_end", 32'(byte_index), 32'd0);

    // Reset during data bit 4
    snap();
    uart_rxd = 1'b0;
    repeat (Bit + 4 * Bit + 20) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (Bit + 10) @(negedge clk);
    check("mid_rst_no_byte", 32'(n_byte - b_byte), 32'd0);
    send_byte(8'h5A, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_nbyte", 32'(n_byte - b_byte), 32'd1);
    check("mid_rst_data", 32'(rx_byte_data), 32'h5A);
    check("mid_rst_index", 32'(byte_index), 32'd1);
    check("mid_rst_nferr", 32'(n_ferr - b_ferr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
